// File: rtl/seq_det_pkg.sv
// Shared constants, types and helpers for the serial pattern detector family.
package seq_det_pkg;

    // Default pattern loaded at reset (MSB is the first bit received).
    localparam logic [3:0] PATTERN_RST_DEF = 4'b1011;
    // Default match counter width.
    localparam int         CNT_W_DEF       = 8;

    // Detection mode selected by the overlap_en input.
    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

    // Increment that sticks at max instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] count,
                                            input logic [31:0] max);
        return (count >= max) ? count : count + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter with a synchronous clear that overrides increment.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear wins over a simultaneous increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = CNT_W'(sat_inc(32'(count_q), 32'(CNT_MAX)));
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-programmable pattern, selectable
// overlapping/non-overlapping detection and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                   PATTERN_W   = 4,
    parameter logic [PATTERN_W-1:0] PATTERN_RST = PATTERN_W'(PATTERN_RST_DEF),
    parameter int                   CNT_W       = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_valid,
    input  logic                 data_in,
    input  logic                 overlap_en,
    input  logic                 pat_load,
    input  logic [PATTERN_W-1:0] pat_in,
    input  logic                 cnt_clr,
    output logic                 detect,
    output logic [CNT_W-1:0]     match_count,
    output logic [PATTERN_W-1:0] pattern
);

    // fill counts 0..PATTERN_W, so it needs one more code than PATTERN_W-1.
    localparam int             FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

    logic [PATTERN_W-1:0] hist_q,    hist_d;
    logic [FILL_W-1:0]    fill_q,    fill_d;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    logic                 detect_q,  detect_d;

    logic                 accept;
    logic [PATTERN_W-1:0] hist_shift;
    logic [FILL_W-1:0]    fill_inc;
    logic                 match;

    // A data bit is taken only when valid and not pre-empted by a pattern load;
    // the match is judged on the history as it will look after the shift.
    always_comb begin
        accept     = data_valid & ~pat_load;
        hist_shift = {hist_q[PATTERN_W-2:0], data_in};
        fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        match      = accept && (fill_inc == FILL_FULL) && (hist_shift == pattern_q);
    end

    // Next-state for history, fill level, active pattern and the detect pulse.
    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        detect_d  = match;
        if (pat_load) begin
            pattern_d = pat_in;
            fill_d    = '0;
        end else if (accept) begin
            hist_d = hist_shift;
            if (match && (ovl_mode_e'(overlap_en) == OVL_OFF)) begin
                fill_d = '0;
            end else begin
                fill_d = fill_inc;
            end
        end
    end

    // Detector state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= PATTERN_RST;
            detect_q  <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            detect_q  <= detect_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (cnt_clr),
        .count (match_count)
    );

    assign detect  = detect_q;
    assign pattern = pattern_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: a queue-based reference model
// predicts each cycle's outputs, a negedge monitor compares them.
module tb_seq_detector_param;

    localparam int         W     = 4;
    localparam int         CW    = 2;
    localparam logic [3:0] PRST  = 4'b1011;
    localparam int         CMAX  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_valid = 1'b0;
    logic          data_in = 1'b0;
    logic          overlap_en = 1'b0;
    logic          pat_load = 1'b0;
    logic [W-1:0]  pat_in = '0;
    logic          cnt_clr = 1'b0;
    logic          detect;
    logic [CW-1:0] match_count;
    logic [W-1:0]  pattern;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic         det;
        int           cnt;
        logic [W-1:0] pat;
    } exp_t;

    exp_t sb[$];

    // Reference model state: accepted bits since last restart, oldest first.
    bit           mdl_bits[$];
    logic [W-1:0] mdl_pat = PRST;
    int           mdl_cnt = 0;

    seq_detector_param #(
        .PATTERN_W   (W),
        .PATTERN_RST (PRST),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .overlap_en  (overlap_en),
        .pat_load    (pat_load),
        .pat_in      (pat_in),
        .cnt_clr     (cnt_clr),
        .detect      (detect),
        .match_count (match_count),
        .pattern     (pattern)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per cycle once a stimulus cycle has completed.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("detect",      longint'(detect),      longint'(e.det));
            chk("match_count", longint'(match_count), longint'(e.cnt));
            chk("pattern",     longint'(pattern),     longint'(e.pat));
        end
    end

    function automatic logic [W-1:0] window();
        logic [W-1:0] v = '0;
        for (int i = 0; i < mdl_bits.size(); i++) v = {v[W-2:0], logic'(mdl_bits[i])};
        return v;
    endfunction

    function automatic void model_reset();
        mdl_bits.delete();
        mdl_pat = PRST;
        mdl_cnt = 0;
    endfunction

    // One clock of stimulus; the prediction is queued after the sampling edge.
    task automatic step(input bit v, input bit d, input bit ovl, input bit pl,
                        input logic [W-1:0] pi, input bit clr);
        exp_t e;
        bit   hit;
        @(negedge clk);
        data_valid = v; data_in = d; overlap_en = ovl;
        pat_load = pl; pat_in = pi; cnt_clr = clr;
        hit = 1'b0;
        if (pl) begin
            mdl_pat = pi;
            mdl_bits.delete();
        end else if (v) begin
            mdl_bits.push_back(d);
            if (mdl_bits.size() > W) void'(mdl_bits.pop_front());
            if (mdl_bits.size() == W && window() == mdl_pat) begin
                hit = 1'b1;
                if (!ovl) mdl_bits.delete();
            end
        end
        if (clr)      mdl_cnt = 0;
        else if (hit) mdl_cnt = (mdl_cnt >= CMAX) ? CMAX : mdl_cnt + 1;
        e.det = hit; e.cnt = mdl_cnt; e.pat = mdl_pat;
        @(posedge clk);
        #1;
        sb.push_back(e);
    endtask

    task automatic bits(input logic [15:0] s, input int n, input bit ovl);
        for (int i = n - 1; i >= 0; i--) step(1, s[i], ovl, 0, '0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
    endtask

    initial begin
        logic [15:0] s;
        #12;
        chk("reset_detect",  longint'(detect),      0);
        chk("reset_count",   longint'(match_count), 0);
        chk("reset_pattern", longint'(pattern),     longint'(PRST));
        @(negedge clk);
        rst = 1'b0;

        // Overlapping: 1011011 -> two matches.
        s = 16'b1011011;       bits(s, 7, 1);
        idle(1);
        step(0, 0, 0, 0, '0, 1);

        // Non-overlapping: same stream then 1011 -> matches after bits 4 and 11.
        s = 16'b10110111011;   bits(s, 11, 0);
        step(0, 0, 0, 0, '0, 1);

        // Valid gaps of three idle cycles between bits.
        s = 16'b1011;
        for (int i = 3; i >= 0; i--) begin
            step(1, s[i], 1, 0, '0, 0);
            idle(3);
        end

        // Load mid-stream: data bit in the load cycle is dropped.
        s = 16'b101;           bits(s, 3, 1);
        step(1, 1, 1, 1, 4'b0110, 0);
        s = 16'b0110;          bits(s, 4, 1);
        idle(1);

        // Saturation: five overlapping matches, then clear with a sixth.
        step(0, 0, 0, 1, 4'b1011, 1);
        s = 16'b1011011011011011; bits(s, 16, 1);
        step(1, 0, 1, 0, '0, 0);
        step(1, 1, 1, 0, '0, 0);
        step(1, 1, 1, 0, '0, 1);
        idle(1);

        // Asynchronous reset between edges, after a partial match and a new pattern.
        step(0, 0, 0, 1, 4'b0011, 0);
        s = 16'b101;           bits(s, 3, 1);
        @(negedge clk);
        data_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        model_reset();
        #1;
        chk("async_detect",  longint'(detect),      0);
        chk("async_count",   longint'(match_count), 0);
        chk("async_pattern", longint'(pattern),     longint'(PRST));
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(1, 1, 1, 0, '0, 0);
        idle(1);
        s = 16'b1011;          bits(s, 4, 1);
        idle(1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 19) == 0), W'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
